// File: rtl/connect_n_engine_if.sv
// rtl/connect_n_engine_if.sv - move handshake, game status and pixel plot bundle for connect_n_engine
interface connect_n_engine_if;
    logic [3:0] col_idx;
    logic       move_valid;
    logic       move_ready;
    logic       new_game;
    logic       move_error;
    logic       current_player;
    logic       game_over;
    logic [1:0] winner;
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (
        output col_idx, move_valid, new_game,
        input  move_ready, move_error, current_player, game_over, winner, x, y, colour, plot
    );

    modport slave (
        input  col_idx, move_valid, new_game,
        output move_ready, move_error, current_player, game_over, winner, x, y, colour, plot
    );
endinterface

// File: rtl/connect_n_engine.sv
// rtl/connect_n_engine.sv - Connect-N game engine with gravity, win/tie detection and per-pixel plot stream
module connect_n_engine #(
    parameter int COLS     = 7,
    parameter int ROWS     = 6,
    parameter int WIN_LEN  = 4,
    parameter int CELL_PX  = 16,
    parameter int X_ORIGIN = 0,
    parameter int Y_ORIGIN = 0
) (
    input  logic                clock,
    input  logic                reset,
    connect_n_engine_if.slave   game
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int HW = $clog2(ROWS + 1);
    localparam int MW = $clog2(ROWS * COLS + 1);
    localparam int PW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam int KW = $clog2(2 * WIN_LEN);
    localparam logic signed [5:0] ROWS_S = 6'(ROWS);
    localparam logic signed [5:0] COLS_S = 6'(COLS);

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_PLACE, S_CHECK, S_DRAW, S_RESULT, S_OVER
    } state_t;

    state_t               state;
    logic [1:0]           cells [ROWS][COLS];
    logic [HW-1:0]        heights [COLS];
    logic [MW-1:0]        moves;
    logic [RW-1:0]        cur_r;
    logic [CW-1:0]        cur_c;
    logic [PW-1:0]        px, py;
    logic [1:0]           dir;
    logic                 side;
    logic [KW-1:0]        run_len, side_len;
    logic signed [5:0]    pr, pc;
    logic                 won;
    logic                 player;
    logic                 move_error;
    logic                 plot;
    logic [1:0]           winner;
    logic [9:0]           x;
    logic [8:0]           y;
    logic [2:0]           colour;

    // Direction vectors: 0 horizontal, 1 vertical, 2 rising diagonal, 3 falling diagonal
    function automatic logic signed [5:0] dr_of(input logic [1:0] d);
        return (d == 2'd0) ? 6'sd0 : 6'sd1;
    endfunction

    function automatic logic signed [5:0] dc_of(input logic [1:0] d);
        case (d)
            2'd0:    return 6'sd1;
            2'd1:    return 6'sd0;
            2'd2:    return 6'sd1;
            default: return -6'sd1;
        endcase
    endfunction

    logic                 restart;
    logic [1:0]           player_code;
    logic [CW-1:0]        col_sel;
    logic [HW-1:0]        sel_height;
    logic                 col_legal;
    logic                 in_range;
    logic                 probe_hit;
    logic [KW-1:0]        run_next;
    logic                 side_done;
    logic                 win_now;
    logic signed [5:0]    base_r, base_c;
    logic signed [5:0]    step_r, step_c;
    logic [1:0]           dir_nx;
    logic                 px_last, py_last;
    logic [9:0]           cell_x;
    logic [8:0]           cell_y;

    always_comb begin
        restart     = game.new_game && (state == S_IDLE || state == S_OVER);
        player_code = player ? 2'b10 : 2'b01;
        col_sel     = game.col_idx[CW-1:0];
        sel_height  = heights[col_sel];
        col_legal   = ({1'b0, game.col_idx} < 5'(COLS)) && (sel_height != HW'(ROWS));

        in_range  = (pr >= 6'sd0) && (pr < ROWS_S) && (pc >= 6'sd0) && (pc < COLS_S);
        probe_hit = in_range && (cells[pr[RW-1:0]][pc[CW-1:0]] == player_code);
        run_next  = run_len + KW'(probe_hit);
        // A side ends on a miss, or once it alone has supplied WIN_LEN-1 matches
        side_done = !probe_hit || (side_len == KW'(WIN_LEN - 2));
        win_now   = run_next >= KW'(WIN_LEN);

        base_r = $signed(6'(cur_r));
        base_c = $signed(6'(cur_c));
        step_r = side ? -dr_of(dir) : dr_of(dir);
        step_c = side ? -dc_of(dir) : dc_of(dir);
        dir_nx = dir + 2'd1;

        px_last = (px == PW'(CELL_PX - 1));
        py_last = (py == PW'(CELL_PX - 1));
        cell_x  = 10'(X_ORIGIN) + 10'(cur_c) * 10'(CELL_PX);
        cell_y  = 9'(Y_ORIGIN) + (9'(ROWS - 1) - 9'(cur_r)) * 9'(CELL_PX);
    end

    always_ff @(posedge clock) begin
        plot       <= 1'b0;
        move_error <= 1'b0;
        if (reset || restart) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    cells[r][c] <= 2'b00;
            for (int c = 0; c < COLS; c++)
                heights[c] <= '0;
            moves  <= '0;
            winner <= 2'b00;
            player <= 1'b0;
            won    <= 1'b0;
            cur_r  <= '0;
            cur_c  <= '0;
            px     <= '0;
            py     <= '0;
            state  <= S_CLEAR;
            if (reset) begin
                x      <= '0;
                y      <= '0;
                colour <= '0;
            end
        end else begin
            case (state)
                // CLEAR sweeps every cell column-major; DRAW repaints only the placed cell
                S_CLEAR, S_DRAW: begin
                    plot   <= 1'b1;
                    x      <= cell_x + 10'(px);
                    y      <= cell_y + 9'(py);
                    colour <= (state == S_CLEAR) ? 3'b001 : (player ? 3'b110 : 3'b100);
                    px     <= px_last ? '0 : px + 1'b1;
                    if (px_last)
                        py <= py_last ? '0 : py + 1'b1;
                    if (px_last && py_last) begin
                        if (state == S_DRAW) begin
                            state <= S_RESULT;
                        end else if (cur_r == RW'(ROWS - 1)) begin
                            cur_r <= '0;
                            if (cur_c == CW'(COLS - 1)) begin
                                cur_c <= '0;
                                state <= S_IDLE;
                            end else begin
                                cur_c <= cur_c + 1'b1;
                            end
                        end else begin
                            cur_r <= cur_r + 1'b1;
                        end
                    end
                end

                S_IDLE: begin
                    if (game.move_valid) begin
                        if (!col_legal) begin
                            move_error <= 1'b1;
                        end else begin
                            cur_c <= col_sel;
                            cur_r <= sel_height[RW-1:0];
                            state <= S_PLACE;
                        end
                    end
                end

                S_PLACE: begin
                    cells[cur_r][cur_c] <= player_code;
                    heights[cur_c]      <= heights[cur_c] + 1'b1;
                    moves               <= moves + 1'b1;
                    won                 <= 1'b0;
                    dir                 <= 2'd0;
                    side                <= 1'b0;
                    side_len            <= '0;
                    run_len             <= KW'(1);
                    pr                  <= base_r + dr_of(2'd0);
                    pc                  <= base_c + dc_of(2'd0);
                    state               <= S_CHECK;
                end

                S_CHECK: begin
                    if (win_now) begin
                        won   <= 1'b1;
                        px    <= '0;
                        py    <= '0;
                        state <= S_DRAW;
                    end else if (!side_done) begin
                        side_len <= side_len + 1'b1;
                        run_len  <= run_next;
                        pr       <= pr + step_r;
                        pc       <= pc + step_c;
                    end else if (!side) begin
                        side     <= 1'b1;
                        side_len <= '0;
                        run_len  <= run_next;
                        pr       <= base_r - dr_of(dir);
                        pc       <= base_c - dc_of(dir);
                    end else if (dir == 2'd3) begin
                        px    <= '0;
                        py    <= '0;
                        state <= S_DRAW;
                    end else begin
                        dir      <= dir_nx;
                        side     <= 1'b0;
                        side_len <= '0;
                        run_len  <= KW'(1);
                        pr       <= base_r + dr_of(dir_nx);
                        pc       <= base_c + dc_of(dir_nx);
                    end
                end

                S_RESULT: begin
                    if (won) begin
                        winner <= player_code;
                        state  <= S_OVER;
                    end else if (moves == MW'(ROWS * COLS)) begin
                        winner <= 2'b00;
                        state  <= S_OVER;
                    end else begin
                        player <= ~player;
                        state  <= S_IDLE;
                    end
                end

                S_OVER: state <= S_OVER;

                default: state <= S_CLEAR;
            endcase
        end
    end

    assign game.move_ready     = (state == S_IDLE);
    assign game.game_over      = (state == S_OVER);
    assign game.move_error     = move_error;
    assign game.current_player = player;
    assign game.winner         = winner;
    assign game.x              = x;
    assign game.y              = y;
    assign game.colour         = colour;
    assign game.plot           = plot;
endmodule

// File: tb/tb_connect_n_engine.sv
// tb/tb_connect_n_engine.sv - directed and randomized checks of connect_n_engine against a board model
module tb_connect_n_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sel;
    logic [3:0] col_drv;
    logic       mv, ng;
    int checks = 0;
    int errors = 0;

    connect_n_engine_if if_a ();
    connect_n_engine_if if_b ();

    assign if_a.col_idx    = col_drv;
    assign if_a.move_valid = mv & ~sel;
    assign if_a.new_game   = ng & ~sel;
    assign if_b.col_idx    = col_drv;
    assign if_b.move_valid = mv & sel;
    assign if_b.new_game   = ng & sel;

    connect_n_engine #(.COLS(7), .ROWS(6), .WIN_LEN(4), .CELL_PX(16), .X_ORIGIN(0), .Y_ORIGIN(0))
        dut_a (.clock(clk), .reset(rst), .game(if_a.slave));
    connect_n_engine #(.COLS(3), .ROWS(3), .WIN_LEN(3), .CELL_PX(4), .X_ORIGIN(100), .Y_ORIGIN(40))
        dut_b (.clock(clk), .reset(rst), .game(if_b.slave));

    logic       s_ready, s_err, s_player, s_over, s_plot;
    logic [1:0] s_winner;
    logic [9:0] s_x;
    logic [8:0] s_y;
    logic [2:0] s_colour;
    assign s_ready  = sel ? if_b.move_ready     : if_a.move_ready;
    assign s_err    = sel ? if_b.move_error     : if_a.move_error;
    assign s_player = sel ? if_b.current_player : if_a.current_player;
    assign s_over   = sel ? if_b.game_over      : if_a.game_over;
    assign s_plot   = sel ? if_b.plot           : if_a.plot;
    assign s_winner = sel ? if_b.winner         : if_a.winner;
    assign s_x      = sel ? if_b.x              : if_a.x;
    assign s_y      = sel ? if_b.y              : if_a.y;
    assign s_colour = sel ? if_b.colour         : if_a.colour;

    // Board model of the selected engine's configuration
    int cols, rows, wl, cpx, xo, yo;
    int brd [16][16];
    int hgt [16];
    int m_player, m_moves, m_over, m_winner;

    int vseq [7]  = '{0, 1, 0, 1, 0, 1, 0};
    int dseq [10] = '{1, 0, 2, 1, 3, 3, 2, 2, 3, 3};
    int tseq [9]  = '{0, 2, 1, 0, 2, 1, 0, 2, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                brd[r][c] = 0;
        for (int c = 0; c < 16; c++)
            hgt[c] = 0;
        m_player = 0; m_moves = 0; m_over = 0; m_winner = 0;
    endtask

    function automatic bit m_wins(input int code);
        int drs [4] = '{0, 1, 1, 1};
        int dcs [4] = '{1, 0, 1, -1};
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                for (int d = 0; d < 4; d++) begin
                    int n = 0;
                    for (int k = 0; k < wl; k++) begin
                        int rr = r + k * drs[d];
                        int cc = c + k * dcs[d];
                        if (rr >= 0 && rr < rows && cc >= 0 && cc < cols && brd[rr][cc] == code) n++;
                    end
                    if (n == wl) return 1'b1;
                end
        return 1'b0;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!s_ready && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(s_ready), 1);
    endtask

    task automatic run_clear(input string tag);
        int cnt = 0, first = -1, last = -1, bad = 0, n = 0;
        int xmin = 100000, xmax = -1, ymin = 100000, ymax = -1;
        bit done = 1'b0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
            if (s_plot) begin
                cnt++;
                if (first < 0) first = n;
                last = n;
                if (s_colour != 3'b001) bad++;
                if (int'(s_x) < xmin) xmin = int'(s_x);
                if (int'(s_x) > xmax) xmax = int'(s_x);
                if (int'(s_y) < ymin) ymin = int'(s_y);
                if (int'(s_y) > ymax) ymax = int'(s_y);
            end
            if (s_ready && !s_plot) done = 1'b1;
        end
        chk({tag, "_clear_done"}, 32'(done), 1);
        chk({tag, "_clear_pixels"}, cnt, cols * rows * cpx * cpx);
        chk({tag, "_clear_contiguous"}, last - first + 1, cnt);
        chk({tag, "_clear_colour"}, bad, 0);
        chk({tag, "_clear_xmin"}, xmin, xo);
        chk({tag, "_clear_xmax"}, xmax, xo + cols * cpx - 1);
        chk({tag, "_clear_ymin"}, ymin, yo);
        chk({tag, "_clear_ymax"}, ymax, yo + rows * cpx - 1);
        chk({tag, "_clear_player"}, 32'(s_player), 0);
        chk({tag, "_clear_over"}, 32'(s_over), 0);
        chk({tag, "_clear_winner"}, 32'(s_winner), 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk({tag, "_rst_plot"}, 32'(s_plot), 0);
        chk({tag, "_rst_xyc"}, {s_x, s_y, s_colour}, 0);
        chk({tag, "_rst_err"}, 32'(s_err), 0);
        chk({tag, "_rst_status"}, {s_over, s_winner, s_player, s_ready}, 0);
        rst = 1'b0;
        model_reset();
        run_clear(tag);
    endtask

    task automatic do_new_game(input string tag);
        ng = 1'b1;
        @(negedge clk);
        ng = 1'b0;
        model_reset();
        run_clear(tag);
    endtask

    task automatic do_move(input int col);
        bit legal, done;
        int r, ecol, x0, y0, n, cnt, bad, errs, distinct;
        bit seen [16][16];
        wait_ready();
        legal = (col < cols) && (hgt[col] < rows);
        col_drv = 4'(col);
        mv = 1'b1;
        @(negedge clk);
        mv = 1'b0;
        if (!legal) begin
            chk("err_pulse", 32'(s_err), 1);
            chk("err_ready", 32'(s_ready), 1);
            @(negedge clk);
            chk("err_pulse_end", 32'(s_err), 0);
            chk("err_player", 32'(s_player), m_player);
            return;
        end
        r = hgt[col];
        brd[r][col] = m_player + 1;
        hgt[col]++;
        m_moves++;
        ecol = (m_player != 0) ? 6 : 4;
        x0 = xo + col * cpx;
        y0 = yo + (rows - 1 - r) * cpx;
        if (m_wins(m_player + 1)) begin
            m_over = 1; m_winner = m_player + 1;
        end else if (m_moves == rows * cols) begin
            m_over = 1; m_winner = 0;
        end else begin
            m_player ^= 1;
        end
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                seen[i][j] = 1'b0;
        n = 0; cnt = 0; bad = 0; errs = 0; distinct = 0; done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            if (s_err) errs++;
            if (s_plot) begin
                cnt++;
                if (int'(s_colour) != ecol || int'(s_x) < x0 || int'(s_x) >= x0 + cpx ||
                    int'(s_y) < y0 || int'(s_y) >= y0 + cpx) begin
                    bad++;
                end else if (!seen[int'(s_x) - x0][int'(s_y) - y0]) begin
                    seen[int'(s_x) - x0][int'(s_y) - y0] = 1'b1;
                    distinct++;
                end
            end
            if ((s_ready || s_over) && !s_plot) done = 1'b1;
        end
        chk("move_done", 32'(done), 1);
        chk("draw_pixels", cnt, cpx * cpx);
        chk("draw_distinct", distinct, cpx * cpx);
        chk("draw_stray", bad, 0);
        chk("move_no_error", errs, 0);
        chk("move_player", 32'(s_player), m_player);
        chk("move_over", 32'(s_over), m_over);
        chk("move_winner", 32'(s_winner), m_winner);
    endtask

    initial begin
        int n, cnt, i;
        rst = 1'b1; mv = 1'b0; ng = 1'b0; col_drv = '0; sel = 1'b0;
        cols = 7; rows = 6; wl = 4; cpx = 16; xo = 0; yo = 0;
        do_reset("a");

        do_move(3);
        chk("col3_player", 32'(s_player), 1);
        for (int k = 0; k < 6; k++) do_move(2);
        do_move(2);
        chk("full_col_player", 32'(s_player), 1);
        do_move(9);
        do_new_game("a_ng1");

        foreach (vseq[k]) do_move(vseq[k]);
        chk("vert_winner", 32'(s_winner), 1);
        chk("vert_over", 32'(s_over), 1);
        col_drv = 4'd4;
        mv = 1'b1;
        @(negedge clk);
        mv = 1'b0;
        chk("over_no_error", 32'(s_err), 0);
        chk("over_not_ready", 32'(s_ready), 0);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (s_plot || s_err) cnt++;
        end
        chk("over_ignored", cnt, 0);
        chk("over_held", 32'(s_over), 1);
        do_new_game("a_ng2");

        foreach (dseq[k]) do_move(dseq[k]);
        chk("diag_winner", 32'(s_winner), 2);
        do_new_game("a_ng3");
        chk("ng3_player", 32'(s_player), 0);

        i = 0;
        while (!m_over && i < 300) begin
            if ($urandom_range(0, 7) == 0) do_move(int'($urandom_range(7, 15)));
            else do_move(int'($urandom_range(0, 6)));
            i++;
        end
        chk("rand_over", 32'(s_over), m_over);

        sel = 1'b1;
        cols = 3; rows = 3; wl = 3; cpx = 4; xo = 100; yo = 40;
        do_reset("b");
        do_move(0);
        wait_ready();
        col_drv = 4'd1;
        mv = 1'b1;
        ng = 1'b1;
        @(negedge clk);
        mv = 1'b0;
        ng = 1'b0;
        model_reset();
        run_clear("b_ng_wins");
        foreach (tseq[k]) do_move(tseq[k]);
        chk("tie_winner", 32'(s_winner), 0);
        chk("tie_over", 32'(s_over), 1);
        do_new_game("b_ng");

        wait_ready();
        col_drv = 4'd1;
        mv = 1'b1;
        @(negedge clk);
        mv = 1'b0;
        n = 0;
        while (!s_plot && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("draw_started", 32'(s_plot), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_draw_plot", 32'(s_plot), 0);
        chk("rst_draw_player", 32'(s_player), 0);
        rst = 1'b0;
        model_reset();
        run_clear("b_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
